cpu_sram_arbiter: RTL and testbench

Sequential arbiter that shares one SRAM-like memory master port between the CPU's instruction-fetch and data-access requesters. It sits between `mips` and the bus bridge. It serialises fetch and load/store transactions and holds each requester's returned data until the pipeline advances. It also produces `i_stall`, `d_stall` and `longest_stall`, which freeze the pipeline.

---
 rtl/cpu_sram_arbiter.sv | 159 +++++++++++++++
 tb/tb_cpu_sram_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sram_arbiter.sv
// ============================================================================
//  Module   : cpu_sram_arbiter
//  Purpose  : Shares one SRAM-like master port between the CPU fetch and data
//             requesters and generates the pipeline stall signals.
//  Option   : ARB_RDATA_BYPASS_EN - forward m_rdata in the data_ok cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_sram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    input  logic        div_stall,
    output logic        i_stall,
    output logic        d_stall,
    output logic        longest_stall,
    output logic        m_req,
    output logic        m_wr,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_owner;
    logic        r_i_done;
    logic        r_d_done;
    logic [31:0] r_i_buf;
    logic [31:0] r_d_buf;
    logic        r_m_req;
    logic        r_m_wr;
    logic [3:0]  r_m_wstrb;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;

    logic        w_i_pend;
    logic        w_d_pend;
    logic        w_cpl;
    logic        w_i_set;
    logic        w_d_set;
    logic        w_i_hit;
    logic        w_d_hit;
    logic        w_longest;

    assign w_i_pend = inst_req & ~r_i_done;
    assign w_d_pend = data_req & ~r_d_done;
    assign w_cpl    = (r_state == S_DATA) & m_data_ok;
    assign w_i_set  = w_cpl & ~r_owner;
    assign w_d_set  = w_cpl &  r_owner;

`ifdef ARB_RDATA_BYPASS_EN
    assign w_i_hit    = w_i_set;
    assign w_d_hit    = w_d_set;
    assign inst_rdata = w_i_hit ? m_rdata : r_i_buf;
    assign data_rdata = w_d_hit ? m_rdata : r_d_buf;
`else
    assign w_i_hit    = 1'b0;
    assign w_d_hit    = 1'b0;
    assign inst_rdata = r_i_buf;
    assign data_rdata = r_d_buf;
`endif

    assign i_stall       = inst_req & ~r_i_done & ~w_i_hit;
    assign d_stall       = data_req & ~r_d_done & ~w_d_hit;
    assign w_longest     = i_stall | d_stall | div_stall;
    assign longest_stall = w_longest;

    assign m_req   = r_m_req;
    assign m_wr    = r_m_wr;
    assign m_wstrb = r_m_wstrb;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_d_pend || w_i_pend) w_state_nxt = S_ADDR;
            S_ADDR:  if (m_addr_ok)            w_state_nxt = S_DATA;
            S_DATA:  if (m_data_ok)            w_state_nxt = S_IDLE;
            default:                           w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner   <= 1'b0;
            r_i_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_i_buf   <= 32'd0;
            r_d_buf   <= 32'd0;
            r_m_req   <= 1'b0;
            r_m_wr    <= 1'b0;
            r_m_wstrb <= 4'd0;
            r_m_addr  <= 32'd0;
            r_m_wdata <= 32'd0;
        end else begin
            // Data wins arbitration: it belongs to the older instruction.
            if (r_state == S_IDLE) begin
                if (w_d_pend) begin
                    r_owner   <= 1'b1;
                    r_m_req   <= 1'b1;
                    r_m_wr    <= data_wr;
                    r_m_wstrb <= data_wr ? data_wstrb : 4'd0;
                    r_m_addr  <= data_addr;
                    r_m_wdata <= data_wdata;
                end else if (w_i_pend) begin
                    r_owner   <= 1'b0;
                    r_m_req   <= 1'b1;
                    r_m_wr    <= 1'b0;
                    r_m_wstrb <= 4'd0;
                    r_m_addr  <= inst_addr;
                    r_m_wdata <= 32'd0;
                end
            end

            if ((r_state == S_ADDR) && m_addr_ok) begin
                r_m_req <= 1'b0;
            end

            if (w_i_set) r_i_buf <= m_rdata;
            if (w_d_set) r_d_buf <= m_rdata;

            // A completion in the same cycle as a pipeline advance keeps the flag set.
            r_i_done <= w_i_set | (r_i_done & w_longest);
            r_d_done <= w_d_set | (r_d_done & w_longest);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_sram_arbiter.sv
// ============================================================================
//  Module   : tb_cpu_sram_arbiter
//  Purpose  : Directed bench for cpu_sram_arbiter with a slave model and a
//             transaction scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        div_stall;
    logic        i_stall;
    logic        d_stall;
    logic        longest_stall;
    logic        m_req;
    logic        m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_addr_ok;
    logic        m_data_ok;
    logic [31:0] m_rdata;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rd_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;
    int addr_dly = 0;
    int data_dly = 0;

    cpu_sram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .div_stall    (div_stall),
        .i_stall      (i_stall),
        .d_stall      (d_stall),
        .longest_stall(longest_stall),
        .m_req        (m_req),
        .m_wr         (m_wr),
        .m_wstrb      (m_wstrb),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_addr_ok    (m_addr_ok),
        .m_data_ok    (m_data_ok),
        .m_rdata      (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Slave model: acknowledges the address after addr_dly cycles of m_req,
    // then returns data_ok data_dly cycles into the data phase.
    initial begin
        int sst;
        int scnt;
        txn_t t;
        sst = 0;
        scnt = 0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        m_rdata   = 32'd0;
        forever begin
            @(negedge clk);
            m_addr_ok = 1'b0;
            m_data_ok = 1'b0;
            if (!rst) begin
                sst  = 0;
                scnt = 0;
            end else if (sst == 0) begin
                if (m_req) begin
                    if (scnt == addr_dly) begin
                        m_addr_ok = 1'b1;
                        n_txn++;
                        if (exp_q.size() == 0) begin
                            chk("sb_unexpected_txn", m_addr, 32'hFFFF_FFFF);
                        end else begin
                            t = exp_q.pop_front();
                            chk("sb_addr",  m_addr, t.addr);
                            chk("sb_wr",    {31'd0, m_wr}, {31'd0, t.wr});
                            chk("sb_wstrb", {28'd0, m_wstrb}, {28'd0, t.strb});
                            if (t.wr) chk("sb_wdata", m_wdata, t.wdata);
                        end
                        sst  = 1;
                        scnt = 0;
                    end else begin
                        scnt++;
                    end
                end
            end else begin
                if (scnt == data_dly) begin
                    m_data_ok = 1'b1;
                    m_rdata   = (rd_q.size() != 0) ? rd_q.pop_front() : 32'd0;
                    sst  = 0;
                    scnt = 0;
                end else begin
                    scnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int d_fall;
        int nreq;
        int base_txn;

        rst = 1'b0;
        inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0;
        data_addr = 32'd0; data_wdata = 32'd0;
        div_stall = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_m_req",      {31'd0, m_req}, 32'd0);
        chk("rst_m_wr",       {31'd0, m_wr}, 32'd0);
        chk("rst_m_wstrb",    {28'd0, m_wstrb}, 32'd0);
        chk("rst_m_addr",     m_addr, 32'd0);
        chk("rst_m_wdata",    m_wdata, 32'd0);
        chk("rst_stalls",     {29'd0, i_stall, d_stall, longest_stall}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single fetch
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        exp_q.push_back('{32'hBFC0_0000, 1'b0, 4'd0, 32'd0});
        rd_q.push_back(32'h3C01_1234);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (i_stall && cyc < 50);
        chk("fetch_latency", cyc, 3);
        chk("fetch_rdata", inst_rdata, 32'h3C01_1234);
        chk("fetch_txn_count", n_txn, 1);
        inst_req = 1'b0;
        @(negedge clk);
        chk("fetch_rdata_hold", inst_rdata, 32'h3C01_1234);
        chk("fetch_idle_stall", {31'd0, longest_stall}, 32'd0);

        // Contention: data must go first
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_1000;
        exp_q.push_back('{32'h8000_1000, 1'b0, 4'd0, 32'd0});
        exp_q.push_back('{32'hBFC0_0004, 1'b0, 4'd0, 32'd0});
        rd_q.push_back(32'hDA7A_0001);
        rd_q.push_back(32'h3C02_0001);
        cyc = 0; d_fall = 0;
        do begin
            @(negedge clk); cyc++;
            if (!d_stall && d_fall == 0) d_fall = cyc;
        end while (longest_stall && cyc < 50);
        chk("cont_d_fall", d_fall, 3);
        chk("cont_longest_len", cyc, 6);
        chk("cont_data_rdata", data_rdata, 32'hDA7A_0001);
        chk("cont_inst_rdata", inst_rdata, 32'h3C02_0001);
        chk("cont_txn_count", n_txn, 3);
        inst_req = 1'b0; data_req = 1'b0;
        @(negedge clk);

        // Store with a two-cycle address wait
        addr_dly = 2;
        data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
        data_addr = 32'h8000_0010; data_wdata = 32'hAABB_CCDD;
        exp_q.push_back('{32'h8000_0010, 1'b1, 4'b0011, 32'hAABB_CCDD});
        rd_q.push_back(32'h1234_5678);
        cyc = 0; nreq = 0;
        do begin
            @(negedge clk); cyc++;
            if (m_req) begin
                nreq++;
                chk("store_m_wr",    {31'd0, m_wr}, 32'd1);
                chk("store_m_wstrb", {28'd0, m_wstrb}, 32'h3);
            end
        end while (d_stall && cyc < 50);
        chk("store_req_cycles", nreq, 3);
        chk("store_latency", cyc, 5);
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'd0;
        addr_dly = 0;
        @(negedge clk);

        // Divider overlap: completed fetch must be held without refetch
        div_stall = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        exp_q.push_back('{32'hBFC0_0008, 1'b0, 4'd0, 32'd0});
        rd_q.push_back(32'h2442_0001);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (i_stall && cyc < 50);
        chk("div_latency", cyc, 3);
        base_txn = n_txn;
        for (int k = 0; k < 5; k++) begin
            chk("div_i_stall_low", {31'd0, i_stall}, 32'd0);
            chk("div_longest",     {31'd0, longest_stall}, 32'd1);
            chk("div_rdata_stable", inst_rdata, 32'h2442_0001);
            if (k < 4) @(negedge clk);
        end
        div_stall = 1'b0;
        @(negedge clk);
        chk("div_done_cleared", {31'd0, i_stall}, 32'd1);
        inst_req = 1'b0;
        @(negedge clk);
        chk("div_no_refetch", n_txn, base_txn);

        // Slow slave
        addr_dly = 3; data_dly = 4;
        inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
        exp_q.push_back('{32'hBFC0_000C, 1'b0, 4'd0, 32'd0});
        rd_q.push_back(32'h8C43_0000);
        cyc = 0; nreq = 0;
        do begin
            @(negedge clk); cyc++;
            if (m_req) begin
                nreq++;
                chk("slow_m_addr", m_addr, 32'hBFC0_000C);
            end
        end while (i_stall && cyc < 50);
        chk("slow_req_cycles", nreq, 4);
        chk("slow_latency", cyc, 10);
        chk("slow_rdata", inst_rdata, 32'h8C43_0000);
        inst_req = 1'b0;
        addr_dly = 0;
        @(negedge clk);

        // Reset while in DATA
        data_dly = 3;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
        exp_q.push_back('{32'hBFC0_0010, 1'b0, 4'd0, 32'd0});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstd_m_req",      {31'd0, m_req}, 32'd0);
        chk("rstd_m_addr",     m_addr, 32'd0);
        chk("rstd_m_wr",       {31'd0, m_wr}, 32'd0);
        chk("rstd_m_wstrb",    {28'd0, m_wstrb}, 32'd0);
        chk("rstd_m_wdata",    m_wdata, 32'd0);
        chk("rstd_inst_rdata", inst_rdata, 32'd0);
        chk("rstd_data_rdata", data_rdata, 32'd0);
        chk("rstd_i_stall",    {31'd0, i_stall}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        rd_q.delete();
        data_dly = 0;
        exp_q.push_back('{32'hBFC0_0010, 1'b0, 4'd0, 32'd0});
        rd_q.push_back(32'h1111_2222);
        rst = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (i_stall && cyc < 50);
        chk("post_rst_latency", cyc, 3);
        chk("post_rst_rdata", inst_rdata, 32'h1111_2222);
        inst_req = 1'b0;
        @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
